// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL lock-qualified reset sequencer.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    RESET,
    WAIT_LOCK,
    HOLD,
    RUN
  } pll_rst_state_t;

  localparam int unsigned    LOSS_COUNT_W   = 8;
  localparam logic [7:0]     LOSS_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/pll_reset_seq_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level; clears to 0 on reset.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) sr <= '0;
    else       sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// Lock-qualified reset sequencer: holds the core in reset until the PLL
// lock flag has been stable for HOLD_CYCLES cycles, re-asserts on lock loss.
// Optional feature macro: PLL_RESET_SEQ_LOSS_COUNT_EN (saturating count of
// lock losses seen in RUN); when undefined lock_loss_count is tied to zero.
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 1024
) (
  input  logic                    clock_in,
  input  logic                    reset,
  input  logic                    locked,
  output logic                    reset_out,
  output logic                    ready,
  output logic                    reset_done,
  output logic [LOSS_COUNT_W-1:0] lock_loss_count
);

  localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  pll_rst_state_t   state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             locked_sync;

  sync_ff #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .d        (locked),
    .q        (locked_sync)
  );

  // Next-state and hold-counter logic.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RESET: begin
        state_next = WAIT_LOCK;
        cnt_next   = '0;
      end
      WAIT_LOCK: begin
        if (locked_sync) begin
          state_next = HOLD;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        if (!locked_sync) begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (!locked_sync) state_next = WAIT_LOCK;
      end
      default: begin
        state_next = RESET;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and registered outputs share one edge so they never skew.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state      <= RESET;
      cnt        <= '0;
      reset_out  <= 1'b1;
      ready      <= 1'b0;
      reset_done <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      reset_out  <= (state_next != RUN);
      ready      <= (state_next == RUN);
      reset_done <= (state_next == RUN) && (state != RUN);
    end
  end

`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  logic loss_event;
  assign loss_event = (state == RUN) && !locked_sync;

  // Saturating lock-loss counter, cleared only by reset.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset)
      lock_loss_count <= '0;
    else if (loss_event && (lock_loss_count != LOSS_COUNT_MAX))
      lock_loss_count <= lock_loss_count + LOSS_COUNT_W'(1);
  end
`else
  assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq (SYNC_STAGES=2, HOLD_CYCLES=16).
module tb_pll_reset_seq;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HOLD = 16;
`ifdef PLL_RESET_SEQ_LOSS_COUNT_EN
  localparam bit LC_EN = 1'b1;
`else
  localparam bit LC_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       locked;
  logic       reset_out;
  logic       ready;
  logic       reset_done;
  logic [7:0] lock_loss_count;

  int total;
  int bad;

  // Reference model: the FSM sees the lock sample taken SYNC edges earlier;
  // the core is released once that delayed lock has been high on HOLD+1
  // consecutive edges (after the first post-reset edge).
  int   edge_n;
  int   streak;
  int   lcnt;
  logic hist[$];

  pll_reset_seq #(.SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)) dut (
    .clock_in        (clk),
    .reset           (reset),
    .locked          (locked),
    .reset_out       (reset_out),
    .ready           (ready),
    .reset_done      (reset_done),
    .lock_loss_count (lock_loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    edge_n = 0;
    streak = 0;
    lcnt   = 0;
    hist.delete();
  endtask

  // One clock: drive locked away from the edge, advance model, compare.
  task automatic tick(input logic lk);
    logic l;
    bit   was_run;
    locked = lk;
    @(posedge clk);
    edge_n++;
    l = 1'b0;
    if (hist.size() >= SYNC) l = hist[hist.size() - SYNC];
    hist.push_back(lk);
    if (hist.size() > SYNC) hist.delete(0);
    was_run = (streak >= int'(HOLD) + 1);
    if (edge_n >= 2 && l) streak++;
    else                  streak = 0;
    if (LC_EN && was_run && !l && edge_n >= 2 && lcnt < 255) lcnt++;
    #1;
    chk("m_ready",      {7'd0, ready},      {7'd0, streak >= int'(HOLD) + 1});
    chk("m_reset_out",  {7'd0, reset_out},  {7'd0, streak <  int'(HOLD) + 1});
    chk("m_reset_done", {7'd0, reset_done}, {7'd0, streak == int'(HOLD) + 1});
    chk("m_loss_count", lock_loss_count,    8'(lcnt));
  endtask

  task automatic ticks(input logic lk, input int n);
    for (int i = 0; i < n; i++) tick(lk);
  endtask

  // Assert reset mid-cycle, check outputs clear without a clock, release mid-cycle.
  task automatic apply_reset();
    #3;
    reset = 1'b1;
    #1;
    chk("rst_reset_out",  {7'd0, reset_out},  8'd1);
    chk("rst_ready",      {7'd0, ready},      8'd0);
    chk("rst_reset_done", {7'd0, reset_done}, 8'd0);
    chk("rst_loss_count", lock_loss_count,    8'd0);
    @(posedge clk);
    @(posedge clk);
    #4;
    reset = 1'b0;
    model_clear();
  endtask

  typedef struct {
    logic       lk;
    int         n;
    logic       ro;
    logic       rdy;
    logic       done;
    logic [7:0] lc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    locked = 1'b0;
    model_clear();
    #2;
    chk("init_reset_out", {7'd0, reset_out}, 8'd1);
    chk("init_ready",     {7'd0, ready},     8'd0);
    @(posedge clk);
    #4;
    reset = 1'b0;

    // Segments of constant locked with the outputs expected at segment end.
    tbl[0]  = '{1'b0, 100, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[1]  = '{1'b1,  18, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[2]  = '{1'b1,   1, 1'b0, 1'b1, 1'b1, 8'd0};
    tbl[3]  = '{1'b1,   1, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[4]  = '{1'b0,   2, 1'b0, 1'b1, 1'b0, 8'd0};
    tbl[5]  = '{1'b0,   1, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[6]  = '{1'b0,   2, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[7]  = '{1'b1,  18, 1'b1, 1'b0, 1'b0, 8'd1};
    tbl[8]  = '{1'b1,   1, 1'b0, 1'b1, 1'b1, 8'd1};
    tbl[9]  = '{1'b0,   5, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[10] = '{1'b1,  13, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[11] = '{1'b0,   3, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[12] = '{1'b1,  18, 1'b1, 1'b0, 1'b0, 8'd2};
    tbl[13] = '{1'b1,   1, 1'b0, 1'b1, 1'b1, 8'd2};
    tbl[14] = '{1'b0,   5, 1'b1, 1'b0, 1'b0, 8'd3};
    tbl[15] = '{1'b1,  19, 1'b0, 1'b1, 1'b1, 8'd3};

    for (int v = 0; v < 16; v++) begin
      ticks(tbl[v].lk, tbl[v].n);
      chk("tbl_reset_out",  {7'd0, reset_out},  {7'd0, tbl[v].ro});
      chk("tbl_ready",      {7'd0, ready},      {7'd0, tbl[v].rdy});
      chk("tbl_reset_done", {7'd0, reset_done}, {7'd0, tbl[v].done});
      chk("tbl_loss_count", lock_loss_count,    LC_EN ? tbl[v].lc : 8'd0);
    end

    // Loss arriving on the edge HOLD would finish: no release, no pulse.
    apply_reset();
    ticks(1'b0, 5);
    ticks(1'b1, 16);
    ticks(1'b0, 2);
    chk("race_ready",      {7'd0, ready},      8'd0);
    chk("race_reset_done", {7'd0, reset_done}, 8'd0);
    ticks(1'b0, 3);

    // Reset mid-HOLD, then full restart from WAIT_LOCK.
    apply_reset();
    ticks(1'b0, 3);
    ticks(1'b1, 10);
    apply_reset();
    ticks(1'b0, 3);
    ticks(1'b1, 19);
    chk("restart_ready", {7'd0, ready}, 8'd1);

    // Reset mid-RUN after some losses.
    ticks(1'b0, 5);
    ticks(1'b1, 25);
    apply_reset();
    ticks(1'b0, 4);
    chk("post_rst_ready", {7'd0, ready}, 8'd0);

    // 300 losses to exercise saturation.
    for (int k = 0; k < 300; k++) begin
      ticks(1'b1, 19);
      ticks(1'b0, 3);
    end
    chk("sat_loss_count", lock_loss_count, LC_EN ? 8'd255 : 8'd0);

    // Randomised lock behaviour with occasional mid-cycle resets.
    apply_reset();
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) apply_reset();
      ticks(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
